decodificador_teclado: RTL
==========================

# decodificador_teclado

Keypad emulator: the transmit-side counterpart of the keypad priority encoder. It accepts BCD digits over a valid/ready handshake, buffers them in a small FIFO and replays each one as a timed one-hot key press on a 10-line numeric keypad bus (`tecladoNumerico`). A press is held for a fixed number of cycles and followed by a release gap. It drives the keypad inputs of encoder-based blocks in self-test and scripted-entry paths.

## Interface
Parameters:
- `PROFUNDIDADE`, default 4: FIFO depth in digits (power of two, ≥2).
- `CICLOS_PRESSAO`, default 3: cycles each key line is held high (≥1).
- `CICLOS_INTERVALO`, default 2: cycles of all-released bus after each press (≥1).

Ports:
- `clock`, input, 1: single clock; everything is rising-edge.
- `resetN`, input, 1: asynchronous, active-low reset.
- `entradaBCD`, input, 4: digit to send.
- `dadoValidoN`, input, 1: active-low strobe; 0 means `entradaBCD` is offered.
- `pronto`, output, 1: 1 when the FIFO can accept a digit.
- `tecladoNumerico`, output, 10: key lines; bit n high means key n is pressed; at most one bit is high.
- `ocupado`, output, 1: 1 while a press or gap is in progress or the FIFO is non-empty.
- `erroBCD`, output, 1: one-cycle pulse when an accepted offer is not a valid BCD digit (value 10–15).

## Operation
- **Handshake.** An offer is taken at a rising edge where `dadoValidoN`=0 and `pronto`=1. The offer is ignored when `pronto`=0, with no error and no side effect.
- **`pronto`.** Equals !full, combinational from the FIFO count only. A pop in the same cycle does not raise it.
- **Invalid values.** A taken offer with `entradaBCD`>9 is discarded, not enqueued. `erroBCD`=1 for the following cycle (registered).
- **FIFO.** Order-preserving, `PROFUNDIDADE` entries. Pointers wrap modulo the depth. A simultaneous push and pop leaves the count unchanged. Popping when empty never occurs.
- **FSM states:**
  - OCIOSO: bus is 0. If the FIFO is non-empty, pop, load the one-hot of the head digit into the output register, set counter=`CICLOS_PRESSAO`-1, and go to PRESSIONA.
  - PRESSIONA: bus holds the one-hot. When counter=0, clear the bus, set counter=`CICLOS_INTERVALO`-1, and go to SOLTA. Otherwise decrement.
  - SOLTA: bus is 0. When counter=0:
    - if the FIFO is non-empty, pop and load directly, entering PRESSIONA (no OCIOSO cycle);
    - otherwise go to OCIOSO.
  - Otherwise decrement.
- **Counter.** Width is the ceiling of log2 of max(`CICLOS_PRESSAO`, `CICLOS_INTERVALO`), minimum 1 bit. It never underflows.
- **`ocupado`.** Equals (state≠OCIOSO) OR (count≠0), combinational.
- **Reset (`resetN`=0), at any point including mid-press:**
  - Asynchronously: state=OCIOSO, FIFO empty, counter=0, `tecladoNumerico`=0, `erroBCD`=0.
  - Reset values: `pronto`=1, `ocupado`=0.
  - No partial press resumes after release.

## Timing
- **First press latency.** A digit taken at edge k with the FSM in OCIOSO and the FIFO otherwise empty is popped at edge k+1. `tecladoNumerico` shows its one-hot from edge k+1 to edge k+1+`CICLOS_PRESSAO` (exactly `CICLOS_PRESSAO` cycles).
- **Gap and idle.** The bus is 0 for exactly `CICLOS_INTERVALO` cycles after the press. The FSM re-enters OCIOSO at edge k+1+P+G if nothing is queued.
- **Back-to-back presses.** Queued digits start every P+G cycles exactly, with no extra idle cycle.
- **Registered outputs.** `tecladoNumerico` and `erroBCD` are registered; there is no combinational path from the inputs to them.
- **`pronto` after a pop.** It reasserts in the cycle after a pop from full.

## Test plan
All scenarios use P=3, G=2, depth 4.
1. **Reset state.** Hold `resetN`=0, then release with no stimulus → `tecladoNumerico`=0, `pronto`=1, `ocupado`=0, `erroBCD`=0.
2. **Single digit.** Offer 7 at edge k → `tecladoNumerico`=10'b0010000000 for edges k+1..k+3, 0 afterwards; `ocupado` falls at edge k+6.
3. **Burst with back-pressure.** Offer 1,2,3,4,5,6,0 every cycle, with `dadoValidoN` held low until each is taken:
   - `pronto` drops while 4 entries are held;
   - keys 1,2,3,4,5,6,0 appear in order, one press start every 5 cycles;
   - none lost or duplicated.
4. **Invalid digit.** Offer 4'd12 while idle → `erroBCD`=1 for exactly one cycle, `tecladoNumerico` stays 0, `ocupado` stays 0. Then offer 4'd9 → bit 9 presses normally.
5. **Reset mid-press.** Queue 9,8,3, then pull `resetN` low during the press of 9 → bus is 0 immediately (asynchronous). After release the bus stays 0 and `ocupado`=0.
6. **Strobe inactive.** Hold `dadoValidoN`=1 while toggling `entradaBCD` 0..15 → no press, no `erroBCD`, `pronto` stays 1.

Source files
------------

// File: rtl/decodificador_teclado.sv
// Keypad emulator: queues BCD digits and replays them as timed one-hot
// key presses on a 10-line numeric keypad bus.
module decodificador_teclado #(
    parameter int PROFUNDIDADE     = 4,
    parameter int CICLOS_PRESSAO   = 3,
    parameter int CICLOS_INTERVALO = 2
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic [3:0] entradaBCD,
    input  logic       dadoValidoN,
    output logic       pronto,
    output logic [9:0] tecladoNumerico,
    output logic       ocupado,
    output logic       erroBCD
);

    localparam int AW   = $clog2(PROFUNDIDADE);
    localparam int MAXC = (CICLOS_PRESSAO > CICLOS_INTERVALO) ?
                          CICLOS_PRESSAO : CICLOS_INTERVALO;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [AW:0]   CHEIO    = PROFUNDIDADE[AW:0];
    localparam logic [CW-1:0] CARGA_P  = CW'(CICLOS_PRESSAO - 1);
    localparam logic [CW-1:0] CARGA_G  = CW'(CICLOS_INTERVALO - 1);

    typedef enum logic [1:0] {
        OCIOSO,
        PRESSIONA,
        SOLTA
    } estado_t;

    estado_t       estado;
    logic [CW-1:0] contador;
    logic [AW:0]   contagem;
    logic [AW-1:0] ptr_esc;
    logic [AW-1:0] ptr_lei;
    logic [3:0]    memoria [PROFUNDIDADE];
    logic [3:0]    cabeca;
    logic          vazia;
    logic          oferta;
    logic          push;
    logic          pop;
    logic          fim;

    function automatic logic [9:0] um_quente(input logic [3:0] d);
        um_quente = 10'd1 << d;
    endfunction

    assign vazia   = (contagem == '0);
    assign pronto  = (contagem != CHEIO);
    assign oferta  = !dadoValidoN && pronto;
    assign push    = oferta && (entradaBCD <= 4'd9);
    assign fim     = (contador == '0);
    assign pop     = !vazia &&
                     ((estado == OCIOSO) || ((estado == SOLTA) && fim));
    assign ocupado = (estado != OCIOSO) || !vazia;
    assign cabeca  = memoria[ptr_lei];

    // FIFO pointers and occupancy; a push and pop together keep the count
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            ptr_esc  <= '0;
            ptr_lei  <= '0;
            contagem <= '0;
        end else begin
            if (push)
                ptr_esc <= ptr_esc + AW'(1);
            if (pop)
                ptr_lei <= ptr_lei + AW'(1);
            if (push && !pop)
                contagem <= contagem + (AW+1)'(1);
            else if (pop && !push)
                contagem <= contagem - (AW+1)'(1);
        end
    end

    // FIFO storage; contents are meaningless while the count is zero
    always_ff @(posedge clock) begin
        if (push)
            memoria[ptr_esc] <= entradaBCD;
    end

    // One-cycle error pulse for a taken offer that is not a BCD digit
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN)
            erroBCD <= 1'b0;
        else
            erroBCD <= oferta && (entradaBCD > 4'd9);
    end

    // Press/gap sequencer with registered key bus
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            estado          <= OCIOSO;
            contador        <= '0;
            tecladoNumerico <= '0;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    tecladoNumerico <= '0;
                    if (!vazia) begin
                        tecladoNumerico <= um_quente(cabeca);
                        contador        <= CARGA_P;
                        estado          <= PRESSIONA;
                    end
                end
                PRESSIONA: begin
                    if (fim) begin
                        tecladoNumerico <= '0;
                        contador        <= CARGA_G;
                        estado          <= SOLTA;
                    end else begin
                        contador <= contador - CW'(1);
                    end
                end
                SOLTA: begin
                    if (fim) begin
                        if (!vazia) begin
                            tecladoNumerico <= um_quente(cabeca);
                            contador        <= CARGA_P;
                            estado          <= PRESSIONA;
                        end else begin
                            estado <= OCIOSO;
                        end
                    end else begin
                        contador <= contador - CW'(1);
                    end
                end
                default: begin
                    estado          <= OCIOSO;
                    contador        <= '0;
                    tecladoNumerico <= '0;
                end
            endcase
        end
    end

endmodule
